// File: rtl/jpeg_cone_eval_scheduler.sv
// ----------------------------------------------------------------------------
// jpeg_cone_eval_scheduler
//
// Purpose:
//   Time-shares a single 12-in / 1-out combinational cone among NUM_REQ
//   requesters. A round-robin arbiter picks one valid request vector. The
//   vector is registered onto cone_in and held for SETTLE_CYCLES full cycles,
//   because the cone is a multicycle path. The cone output is then sampled
//   and returned with the id of the requester that supplied the vector.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst        synchronous active-high reset (wins over everything)
//   req_valid  per-requester valid
//   req_vec    requester i vector at [i*VEC_W +: VEC_W]
//   req_ready  one-hot accept strobe (combinational, IDLE only)
//   cone_in    registered cone drive, holds the last launched vector
//   cone_out   cone result
//   rsp_valid  result valid, held until rsp_ready
//   rsp_ready  consumer accept
//   rsp_id     requester that produced rsp_bit
//   rsp_bit    sampled cone_out
//   busy       high whenever the FSM is not IDLE
// ----------------------------------------------------------------------------
module jpeg_cone_eval_scheduler #(
  parameter int NUM_REQ       = 4,
  parameter int VEC_W         = 12,
  parameter int SETTLE_CYCLES = 2,
  parameter int ID_W          = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*VEC_W-1:0] req_vec,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [VEC_W-1:0]         cone_in,
  input  logic                     cone_out,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     rsp_bit,
  output logic                     busy
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  generate
    if (SETTLE_CYCLES < 1 || NUM_REQ < 2) begin : g_bad_params
      $error("jpeg_cone_eval_scheduler: need SETTLE_CYCLES>=1 and NUM_REQ>=2");
    end
  endgenerate

  logic [1:0]       state_q, state_d;
  logic [VEC_W-1:0] cone_in_q, cone_in_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic [ID_W-1:0]  last_grant_q, last_grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_bit_q, rsp_bit_d;

  logic [NUM_REQ-1:0][VEC_W-1:0] req_vec_a;
  logic                          grant_vld;
  logic [ID_W-1:0]               grant_idx;
  logic                          accept;

  assign req_vec_a = req_vec;

  // Round-robin pick. Prefer the lowest valid index above last_grant.
  // If there is none, wrap to the lowest valid index overall.
  always_comb begin
    logic            hi_found, lo_found;
    logic [ID_W-1:0] hi_idx, lo_idx;
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && !hi_found && (i > int'(last_grant_q))) begin
        hi_found = 1'b1;
        hi_idx   = ID_W'(i);
      end
      if (req_valid[i] && !lo_found) begin
        lo_found = 1'b1;
        lo_idx   = ID_W'(i);
      end
    end
    grant_vld = |req_valid;
    grant_idx = hi_found ? hi_idx : lo_idx;
  end

  // Reset is gated in so a handshake cannot complete during a cycle
  // whose state update reset discards.
  assign accept    = (state_q == ST_IDLE) && grant_vld && !rst;
  assign req_ready = accept ? (NUM_REQ'(1) << grant_idx) : '0;

  always_comb begin
    state_d      = state_q;
    cone_in_d    = cone_in_q;
    rsp_id_d     = rsp_id_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_bit_d    = rsp_bit_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cone_in_d    = req_vec_a[grant_idx];
          rsp_id_d     = grant_idx;
          last_grant_d = grant_idx;
          cnt_d        = CNT_W'(SETTLE_CYCLES - 1);
          state_d      = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        // When cnt reaches 0, cone_in has been stable for SETTLE_CYCLES
        // full cycles by the coming edge.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          rsp_bit_d   = cone_out;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cone_in_q    <= '0;
      rsp_id_q     <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      cnt_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_bit_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cone_in_q    <= cone_in_d;
      rsp_id_q     <= rsp_id_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_bit_q    <= rsp_bit_d;
    end
  end

  assign cone_in   = cone_in_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_bit   = rsp_bit_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_jpeg_cone_eval_scheduler.sv
module tb_jpeg_cone_eval_scheduler;
  localparam int NR = 4;
  localparam int VW = 12;
  localparam int SC = 2;
  localparam int IW = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NR-1:0]    req_valid;
  logic [NR*VW-1:0] req_vec;
  logic [NR-1:0]    req_ready;
  logic [VW-1:0]    cone_in;
  logic             cone_out;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [IW-1:0]    rsp_id;
  logic             rsp_bit;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Golden cone: inverted (parity of v XOR (v[11] & v[0])).
  function automatic logic cone_fn(input logic [VW-1:0] v);
    return ~((^v) ^ (v[11] & v[0]));
  endfunction

  assign cone_out = cone_fn(cone_in);

  jpeg_cone_eval_scheduler #(.NUM_REQ(NR), .VEC_W(VW), .SETTLE_CYCLES(SC), .ID_W(IW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_vec(req_vec), .req_ready(req_ready),
    .cone_in(cone_in), .cone_out(cone_out), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_bit(rsp_bit), .busy(busy)
  );

  // Cycle discipline: drive at posedge+1, check at negedge.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic drain();
    req_valid = '0; rsp_ready = 1'b1;
    repeat (8) tick();
  endtask

  task automatic wait_grant(output logic [NR-1:0] g);
    g = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin g = req_ready; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
    n_checks++; if (cone_in !== 12'h000) begin n_fail++; $display("FAIL rst_cone_in: got %h expected 000", cone_in); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b expected 0", rsp_valid); end
    n_checks++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL rst_rsp_id: got %0d expected 0", rsp_id); end
    n_checks++; if (rsp_bit !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_bit: got %b expected 0", rsp_bit); end
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_req_ready: got %b expected 0000", req_ready); end
    tick();
  endtask

  task automatic test_single();
    do_reset();
    rsp_ready = 1'b1; req_vec = '0; req_vec[11:0] = 12'hA5C; req_valid = 4'b0001;
    @(negedge clk);  // cycle 0
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL t1_req_ready: got %b expected 0001", req_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL t1_busy_c0: got %b expected 0", busy); end
    tick(); req_valid = '0;
    @(negedge clk);  // cycle 1
    n_checks++; if (cone_in !== 12'hA5C) begin n_fail++; $display("FAIL t1_cone_in_c1: got %h expected a5c", cone_in); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL t1_busy_c1: got %b expected 1", busy); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL t1_rsp_valid_c1: got %b expected 0", rsp_valid); end
    tick();
    @(negedge clk);  // cycle 2
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL t1_rsp_valid_c2: got %b expected 0", rsp_valid); end
    n_checks++; if (cone_in !== 12'hA5C) begin n_fail++; $display("FAIL t1_cone_in_c2: got %h expected a5c", cone_in); end
    tick();
    @(negedge clk);  // cycle 3
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL t1_rsp_valid_c3: got %b expected 1", rsp_valid); end
    n_checks++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL t1_rsp_id: got %0d expected 0", rsp_id); end
    n_checks++; if (rsp_bit !== 1'b1) begin n_fail++; $display("FAIL t1_rsp_bit: got %b expected 1", rsp_bit); end
    tick();
    @(negedge clk);  // cycle 4
    n_checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL t1_idle_c4: got busy=%b rsp_valid=%b expected 0 0", busy, rsp_valid); end
    tick();
    drain();
  endtask

  task automatic test_back_to_back();
    int exp_order[5] = '{0, 1, 2, 3, 0};
    logic [NR-1:0] one = 4'b0001;
    int n_acc = 0;
    int n_rsp = 0;
    int last_c = 0;
    do_reset();
    rsp_ready = 1'b1; req_vec = {12'hD03, 12'h702, 12'h501, 12'h300}; req_valid = 4'b1111;
    for (int c = 0; c < 30 && n_acc < 5; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        n_checks++;
        if (req_ready !== (one << exp_order[n_acc])) begin
          n_fail++; $display("FAIL t2_grant%0d: got %b expected requester %0d", n_acc, req_ready, exp_order[n_acc]);
        end
        if (n_acc > 0) begin
          n_checks++;
          if (c - last_c != 4) begin n_fail++; $display("FAIL t2_spacing%0d: got %0d expected 4", n_acc, c - last_c); end
        end
        last_c = c; n_acc++;
      end
      if (rsp_valid && n_rsp < 5) begin
        n_checks++;
        if (rsp_id !== IW'(exp_order[n_rsp])) begin
          n_fail++; $display("FAIL t2_rsp_id%0d: got %0d expected %0d", n_rsp, rsp_id, exp_order[n_rsp]);
        end
        n_rsp++;
      end
      tick();
    end
    n_checks++; if (n_acc != 5) begin n_fail++; $display("FAIL t2_accept_count: got %0d expected 5", n_acc); end
    drain();
  endtask

  task automatic test_priority();
    logic [NR-1:0] g;
    do_reset();
    rsp_ready = 1'b1; req_vec = {12'h111, 12'h222, 12'h333, 12'h444}; req_valid = 4'b0010;
    wait_grant(g);
    n_checks++; if (g !== 4'b0010) begin n_fail++; $display("FAIL t3_first: got %b expected 0010", g); end
    tick(); req_valid = 4'b0101;
    wait_grant(g);
    n_checks++; if (g !== 4'b0100) begin n_fail++; $display("FAIL t3_after1: got %b expected 0100", g); end
    tick(); req_valid = 4'b0001;
    wait_grant(g);
    n_checks++; if (g !== 4'b0001) begin n_fail++; $display("FAIL t3_wrap: got %b expected 0001", g); end
    tick();
    drain();
  endtask

  task automatic test_backpressure();
    do_reset();
    rsp_ready = 1'b0; req_vec = '0; req_vec[47:36] = 12'h3C1; req_valid = 4'b1000;
    @(negedge clk);
    n_checks++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL t4_grant: got %b expected 1000", req_ready); end
    tick(); req_valid = 4'b1111;
    repeat (2) begin @(negedge clk); tick(); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      // cone(3C1): parity 1, v[11]&v[0]=0 -> inverted -> 0
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_bit !== 1'b0 || req_ready !== 4'b0000 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL t4_hold%0d: got valid=%b id=%0d bit=%b ready=%b busy=%b expected 1 3 0 0000 1",
                 k, rsp_valid, rsp_id, rsp_bit, req_ready, busy);
      end
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL t4_ready_cycle: got valid=%b busy=%b expected 1 1", rsp_valid, busy); end
    tick();
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL t4_idle: got busy=%b valid=%b expected 0 0", busy, rsp_valid); end
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL t4_next_grant: got %b expected 0001", req_ready); end
    tick();
    drain();
  endtask

  task automatic test_reset_abort();
    do_reset();
    rsp_ready = 1'b1; req_vec = '0; req_vec[23:12] = 12'h777; req_valid = 4'b0010;
    @(negedge clk);
    n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL t5_grant: got %b expected 0010", req_ready); end
    tick(); req_valid = '0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b1 || cone_in !== 12'h777) begin n_fail++; $display("FAIL t5_settle: got busy=%b cone_in=%h expected 1 777", busy, cone_in); end
    tick(); rst = 1'b1;
    @(negedge clk);
    tick(); rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || cone_in !== 12'h000) begin
      n_fail++; $display("FAIL t5_after_rst: got busy=%b valid=%b cone_in=%h expected 0 0 000", busy, rsp_valid, cone_in);
    end
    for (int k = 0; k < 6; k++) begin
      tick();
      @(negedge clk);
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL t5_no_rsp%0d: got %b expected 0", k, rsp_valid); end
    end
    tick(); req_valid = 4'b0011;
    @(negedge clk);
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL t5_ptr_reset: got %b expected 0001", req_ready); end
    tick();
    drain();
  endtask

  task automatic test_random();
    logic [VW-1:0] q_vec[$];
    logic [IW-1:0] q_id[$];
    logic [63:0]   r;
    logic [VW-1:0] v;
    logic [IW-1:0] eid;
    int n_acc = 0;
    int n_rsp = 0;
    int id;
    do_reset();
    for (int c = 0; c < 40000 && !(n_acc == 1000 && q_id.size() == 0); c++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      if (n_acc < 1000) begin
        req_valid = 4'($urandom());
        r = {$urandom(), $urandom()};
        req_vec = r[NR*VW-1:0];
      end else begin
        req_valid = '0;
      end
      @(negedge clk);
      if (req_ready != '0) begin
        n_checks++;
        if (!$onehot(req_ready) || (req_ready & ~req_valid) != '0) begin
          n_fail++; $display("FAIL t6_grant_legal: got ready=%b valid=%b", req_ready, req_valid);
        end
        id = 0;
        for (int i = 0; i < NR; i++) if (req_ready[i]) id = i;
        q_id.push_back(IW'(id));
        q_vec.push_back(req_vec[id*VW +: VW]);
        n_acc++;
      end
      if (rsp_valid && rsp_ready) begin
        n_checks++;
        if (q_id.size() == 0) begin
          n_fail++; $display("FAIL t6_extra_rsp: got id=%0d expected no response", rsp_id);
        end else begin
          eid = q_id.pop_front();
          v   = q_vec.pop_front();
          if (rsp_id !== eid || rsp_bit !== cone_fn(v)) begin
            n_fail++; $display("FAIL t6_rsp%0d: got id=%0d bit=%b expected id=%0d bit=%b (vec %h)", n_rsp, rsp_id, rsp_bit, eid, cone_fn(v), v);
          end
        end
        n_rsp++;
      end
      tick();
    end
    n_checks++;
    if (n_acc != 1000 || n_rsp != 1000) begin
      n_fail++; $display("FAIL t6_counts: got accepts=%0d responses=%0d expected 1000 1000", n_acc, n_rsp);
    end
    drain();
  endtask

  initial begin
    req_valid = '0; req_vec = '0; rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_priority();
    test_backpressure();
    test_reset_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
